// File: rtl/arb_rr_bin.sv
// arb_rr_bin: round-robin arbiter with registered binary/one-hot grant and valid/ready handshake
// Ports: clk, rst (sync, active-high), req[WIDTH] requests, vld grant presented,
//        rdy downstream accept, bin[WIDTH_LOG] granted index, oht[WIDTH] one-hot grant.
module arb_rr_bin #(
  parameter int WIDTH = 32,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  output logic                 vld,
  input  logic                 rdy,
  output logic [WIDTH_LOG-1:0] bin,
  output logic [WIDTH-1:0]     oht
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  state_t state, state_nxt;
  logic [WIDTH_LOG-1:0] ptr, ptr_nxt, bin_nxt, ptr_inc, base, found;
  logic xfer, any;
  assign vld = state == GRANT;
  assign xfer = vld && rdy;
  assign any = |req;
  assign ptr_inc = int'(bin) == WIDTH - 1 ? '0 : bin + 1'b1;
  // A transfer searches from the post-transfer pointer in the same cycle.
  assign base = xfer ? ptr_inc : ptr;
  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    found = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      int k;
      k = int'(base) + i;
      k = k >= WIDTH ? k - WIDTH : k;
      if (req[k]) found = WIDTH_LOG'(k);
    end
  end
  always_comb begin
    state_nxt = state;
    bin_nxt = bin;
    ptr_nxt = ptr;
    if (state == IDLE) begin
      state_nxt = any ? GRANT : IDLE;
      bin_nxt = any ? found : bin;
    end else if (rdy) begin
      ptr_nxt = ptr_inc;
      state_nxt = any ? GRANT : IDLE;
      bin_nxt = any ? found : bin;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bin <= '0;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      bin <= bin_nxt;
      ptr <= ptr_nxt;
    end
  end
  always_comb begin
    oht = '0;
    for (int i = 0; i < WIDTH; i++) oht[i] = vld && int'(bin) == i;
  end
endmodule

// File: tb/tb_arb_rr_bin.sv
// tb_arb_rr_bin: scoreboard bench for arb_rr_bin against a queue-fed reference model
module tb_arb_rr_bin;
  localparam int W = 8;
  localparam int WL = $clog2(W);
  logic clk = 0;
  logic rst = 1;
  logic [W-1:0] req = '0;
  logic rdy = 0;
  logic vld;
  logic [WL-1:0] bin;
  logic [W-1:0] oht;
  int errors = 0;
  int checks = 0;
  typedef struct {bit v; int b;} exp_t;
  exp_t sb[$];
  int m_vld = 0, m_bin = 0, m_ptr = 0;
  bit done = 0;

  arb_rr_bin #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .req(req), .vld(vld), .rdy(rdy), .bin(bin), .oht(oht));

  always #5 clk = ~clk;

  function automatic int pick(int p, logic [W-1:0] r);
    for (int o = 0; o < W; o++) if (r[(p + o) % W]) return (p + o) % W;
    return 0;
  endfunction

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      if (rst) begin
        m_vld = 0; m_bin = 0; m_ptr = 0;
      end else if (m_vld == 0) begin
        if (req != 0) begin m_bin = pick(m_ptr, req); m_vld = 1; end
      end else if (rdy) begin
        m_ptr = (m_bin + 1) % W;
        if (req != 0) m_bin = pick(m_ptr, req);
        else m_vld = 0;
      end
      e.v = m_vld != 0;
      e.b = m_bin;
      sb.push_back(e);
    end
  end

  initial begin
    forever begin
      exp_t e;
      logic [W-1:0] eo;
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        eo = e.v ? W'(1) << e.b : '0;
        checks++;
        if (vld !== e.v || int'(bin) != e.b || oht !== eo) begin
          errors++;
          $display("FAIL grant t=%0t: vld=%b bin=%0d oht=%b, required vld=%b bin=%0d oht=%b",
                   $time, vld, bin, oht, e.v, e.b, eo);
        end
      end
    end
  end

  task automatic step(input logic [W-1:0] r, input logic y, input logic s, input int n);
    for (int i = 0; i < n; i++) begin
      req = r; rdy = y; rst = s;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step('0, 0, 1, 2);
    step('0, 1, 0, 5);
    step('0, 0, 0, 2);
    step(8'b0010_0000, 0, 0, 1);
    step(8'b0000_0011, 0, 0, 4);
    step(8'b0000_0011, 1, 0, 1);
    step('1, 1, 0, 16);
    step('0, 1, 0, 2);
    step(8'b0010_0000, 1, 0, 1);
    step(8'b1000_0001, 1, 0, 3);
    step(8'b0000_0001, 1, 0, 4);
    step(8'b0000_0100, 0, 0, 2);
    step(8'b0000_0100, 1, 1, 1);
    step('0, 1, 0, 2);
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] r;
      r = W'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & W'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, 1);
    end
    step('0, 1, 0, 3);
    done = 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() > 1) begin
      errors++;
      $display("FAIL drain: pending=%0d, required<=1", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
